// File: rtl/serial_frame_tx_uc.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx_uc
// Description : Frame transmit controller. It sends N_BYTES through the serial
//               TX, then waits for the frame acknowledge with a timeout and a
//               bounded number of retries.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx_uc #(
    parameter int N_BYTES     = 4,
    parameter int TIMEOUT     = 50000,
    parameter int MAX_RETRIES = 3,
    parameter int CONTINUO    = 0,
    localparam int W_IDX      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1,
    localparam int W_RET      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             transmite,
    input  logic             pronto_tx,
    input  logic             fim_rx,
    output logic             partida_tx,
    output logic             zera,
    output logic [W_IDX-1:0] indice_byte,
    output logic [W_RET-1:0] tentativas,
    output logic             fim_transmissao,
    output logic             erro,
    output logic [3:0]       db_estado
);

    localparam int W_TMO = $clog2(TIMEOUT);

    // State codes double as the debug display codes.
    localparam logic [3:0] c_INICIAL     = 4'h0;
    localparam logic [3:0] c_PREPARACAO  = 4'h1;
    localparam logic [3:0] c_PARTIDA     = 4'h2;
    localparam logic [3:0] c_AGUARDA_TX  = 4'h3;
    localparam logic [3:0] c_INCREMENTA  = 4'h4;
    localparam logic [3:0] c_ESPERA_RX   = 4'h5;
    localparam logic [3:0] c_RETENTATIVA = 4'h6;
    localparam logic [3:0] c_FALHA       = 4'hA;
    localparam logic [3:0] c_FINAL_TX    = 4'hF;

    localparam logic [W_IDX-1:0] c_IDX_LAST = W_IDX'(N_BYTES - 1);
    localparam logic [W_RET-1:0] c_RET_MAX  = W_RET'(MAX_RETRIES);
    localparam logic [W_TMO-1:0] c_TMO_LAST = W_TMO'(TIMEOUT - 1);

    logic [3:0]       r_estado;
    logic [3:0]       w_proximo;
    logic [W_IDX-1:0] r_indice;
    logic [W_RET-1:0] r_tentativas;
    logic [W_TMO-1:0] r_contador;
    logic             r_erro;
    logic             w_timeout;

    assign w_timeout = (r_contador == c_TMO_LAST);

    always_comb begin
        w_proximo = c_INICIAL;
        case (r_estado)
            c_INICIAL:     w_proximo = transmite ? c_PREPARACAO : c_INICIAL;
            c_PREPARACAO:  w_proximo = c_PARTIDA;
            c_PARTIDA:     w_proximo = c_AGUARDA_TX;
            c_AGUARDA_TX: begin
                if (!pronto_tx)
                    w_proximo = c_AGUARDA_TX;
                else if (r_indice == c_IDX_LAST)
                    w_proximo = c_ESPERA_RX;
                else
                    w_proximo = c_INCREMENTA;
            end
            c_INCREMENTA:  w_proximo = c_PARTIDA;
            c_ESPERA_RX: begin
                // An acknowledge takes precedence over a coincident timeout.
                if (fim_rx)
                    w_proximo = c_FINAL_TX;
                else if (!w_timeout)
                    w_proximo = c_ESPERA_RX;
                else if (r_tentativas == c_RET_MAX)
                    w_proximo = c_FALHA;
                else
                    w_proximo = c_RETENTATIVA;
            end
            c_RETENTATIVA: w_proximo = c_PARTIDA;
            c_FINAL_TX:    w_proximo = ((CONTINUO != 0) && transmite) ? c_PREPARACAO : c_INICIAL;
            c_FALHA:       w_proximo = c_INICIAL;
            default:       w_proximo = c_INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_estado <= c_INICIAL;
        else
            r_estado <= w_proximo;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_indice     <= '0;
            r_tentativas <= '0;
            r_erro       <= 1'b0;
        end else begin
            case (r_estado)
                c_PREPARACAO: begin
                    r_indice     <= '0;
                    r_tentativas <= '0;
                    r_erro       <= 1'b0;
                end
                c_INCREMENTA:  r_indice <= r_indice + W_IDX'(1);
                c_RETENTATIVA: begin
                    r_indice     <= '0;
                    r_tentativas <= r_tentativas + W_RET'(1);
                end
                c_FALHA:       r_erro <= 1'b1;
                default: ;
            endcase
        end
    end

    // Held at zero outside espera_rx, so every entry starts a fresh count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_contador <= '0;
        else if (r_estado == c_ESPERA_RX)
            r_contador <= r_contador + W_TMO'(1);
        else
            r_contador <= '0;
    end

    always_comb begin
        db_estado = 4'hE;
        case (r_estado)
            c_INICIAL, c_PREPARACAO, c_PARTIDA, c_AGUARDA_TX, c_INCREMENTA,
            c_ESPERA_RX, c_RETENTATIVA, c_FALHA, c_FINAL_TX: db_estado = r_estado;
            default: db_estado = 4'hE;
        endcase
    end

    assign partida_tx      = (r_estado == c_PARTIDA);
    assign zera            = (r_estado == c_PREPARACAO);
    assign fim_transmissao = (r_estado == c_FINAL_TX);
    assign indice_byte     = r_indice;
    assign tentativas      = r_tentativas;
    assign erro            = r_erro;

endmodule
`default_nettype wire
